// File: rtl/vga_timing_gen.sv
// Two-axis VGA timing generator advanced by a pixel-tick enable.
// Timing offered on the cfg port is validated, held in a shadow set and applied only at a frame boundary.
module vga_timing_gen #(
  parameter int H_WIDTH      = 12,
  parameter int V_WIDTH      = 11,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int DEF_H_ACTIVE = 640,
  parameter int DEF_H_FP     = 16,
  parameter int DEF_H_SYNC   = 96,
  parameter int DEF_H_BP     = 48,
  parameter int DEF_V_ACTIVE = 480,
  parameter int DEF_V_FP     = 10,
  parameter int DEF_V_SYNC   = 2,
  parameter int DEF_V_BP     = 33
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [H_WIDTH-1:0] cfg_h_active,
  input  logic [H_WIDTH-1:0] cfg_h_fp,
  input  logic [H_WIDTH-1:0] cfg_h_sync,
  input  logic [H_WIDTH-1:0] cfg_h_bp,
  input  logic [V_WIDTH-1:0] cfg_v_active,
  input  logic [V_WIDTH-1:0] cfg_v_fp,
  input  logic [V_WIDTH-1:0] cfg_v_sync,
  input  logic [V_WIDTH-1:0] cfg_v_bp,
  output logic               cfg_err,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [H_WIDTH-1:0] x,
  output logic [V_WIDTH-1:0] y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int HX = H_WIDTH + 2;
  localparam int VX = V_WIDTH + 2;
  localparam logic [HX-1:0] H_LIMIT = {2'b01, {H_WIDTH{1'b0}}};
  localparam logic [VX-1:0] V_LIMIT = {2'b01, {V_WIDTH{1'b0}}};

  typedef struct packed {
    logic [H_WIDTH-1:0] ha, hfp, hs, hbp;
    logic [V_WIDTH-1:0] va, vfp, vs, vbp;
  } timing_t;

  localparam timing_t DEF_TIMING = '{
    ha:  H_WIDTH'(DEF_H_ACTIVE), hfp: H_WIDTH'(DEF_H_FP),
    hs:  H_WIDTH'(DEF_H_SYNC),   hbp: H_WIDTH'(DEF_H_BP),
    va:  V_WIDTH'(DEF_V_ACTIVE), vfp: V_WIDTH'(DEF_V_FP),
    vs:  V_WIDTH'(DEF_V_SYNC),   vbp: V_WIDTH'(DEF_V_BP)
  };

  typedef enum logic [1:0] {CFG_IDLE, CFG_CHECK, CFG_PEND} cfg_state_t;

  // Totals carry two guard bits so four full-scale fields cannot wrap.
  function automatic logic [HX-1:0] h_sum(input timing_t t);
    return HX'(t.ha) + HX'(t.hfp) + HX'(t.hs) + HX'(t.hbp);
  endfunction

  function automatic logic [VX-1:0] v_sum(input timing_t t);
    return VX'(t.va) + VX'(t.vfp) + VX'(t.vs) + VX'(t.vbp);
  endfunction

  timing_t            work_q, shadow_q;
  cfg_state_t         state_q;
  logic [H_WIDTH-1:0] hcnt_q, hcnt_d, x_q;
  logic [V_WIDTH-1:0] vcnt_q, vcnt_d, y_q;
  logic               hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
  logic               cfg_ready_q, cfg_err_q;

  logic [HX-1:0] h_total, h_sync_beg, h_sync_end, hcnt_x, sh_h_total;
  logic [VX-1:0] v_total, v_sync_beg, v_sync_end, vcnt_x, sh_v_total;
  logic          h_last, v_last, frame_end, in_hsync, in_vsync, shadow_ok, apply;

  assign h_total    = h_sum(work_q);
  assign h_sync_beg = HX'(work_q.ha) + HX'(work_q.hfp);
  assign h_sync_end = h_sync_beg + HX'(work_q.hs);
  assign hcnt_x     = HX'(hcnt_q);
  assign h_last     = (hcnt_x + HX'(1)) == h_total;
  assign in_hsync   = (hcnt_x >= h_sync_beg) && (hcnt_x < h_sync_end);

  assign v_total    = v_sum(work_q);
  assign v_sync_beg = VX'(work_q.va) + VX'(work_q.vfp);
  assign v_sync_end = v_sync_beg + VX'(work_q.vs);
  assign vcnt_x     = VX'(vcnt_q);
  assign v_last     = (vcnt_x + VX'(1)) == v_total;
  assign in_vsync   = (vcnt_x >= v_sync_beg) && (vcnt_x < v_sync_end);

  assign frame_end  = enable && h_last && v_last;

  assign sh_h_total = h_sum(shadow_q);
  assign sh_v_total = v_sum(shadow_q);
  assign shadow_ok  = (shadow_q.ha != '0) && (shadow_q.hfp != '0) &&
                      (shadow_q.hs != '0) && (shadow_q.hbp != '0) &&
                      (shadow_q.va != '0) && (shadow_q.vfp != '0) &&
                      (shadow_q.vs != '0) && (shadow_q.vbp != '0) &&
                      (sh_h_total <= H_LIMIT) && (sh_v_total <= V_LIMIT);

  // A shadow captured on this very edge is still in CFG_IDLE, so it waits a full frame.
  assign apply = frame_end && ((state_q == CFG_CHECK && shadow_ok) || state_q == CFG_PEND);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (enable) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + V_WIDTH'(1);
      end else begin
        hcnt_d = hcnt_q + H_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q        <= DEF_TIMING;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (enable) begin
        hsync_q       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
        vsync_q       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
        active_q      <= (hcnt_q < work_q.ha) && (vcnt_q < work_q.va);
        x_q           <= hcnt_q;
        y_q           <= vcnt_q;
        line_start_q  <= (hcnt_q == '0);
        frame_start_q <= (hcnt_q == '0) && (vcnt_q == '0);
      end
      if (apply) begin
        work_q <= shadow_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CFG_IDLE;
      shadow_q    <= DEF_TIMING;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        CFG_IDLE: begin
          if (cfg_valid) begin
            shadow_q    <= '{ha: cfg_h_active, hfp: cfg_h_fp, hs: cfg_h_sync, hbp: cfg_h_bp,
                             va: cfg_v_active, vfp: cfg_v_fp, vs: cfg_v_sync, vbp: cfg_v_bp};
            cfg_ready_q <= 1'b0;
            state_q     <= CFG_CHECK;
          end
        end
        CFG_CHECK: begin
          if (!shadow_ok) begin
            cfg_err_q   <= 1'b1;
            cfg_ready_q <= 1'b1;
            state_q     <= CFG_IDLE;
          end else if (frame_end) begin
            cfg_ready_q <= 1'b1;
            state_q     <= CFG_IDLE;
          end else begin
            state_q <= CFG_PEND;
          end
        end
        CFG_PEND: begin
          if (frame_end) begin
            cfg_ready_q <= 1'b1;
            state_q     <= CFG_IDLE;
          end
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a frame-position model (pixel index p, split by div/mod) is compared every clk,
// alongside directed literal checks and a randomized enable/config phase.
module tb_vga_timing_gen;

  localparam int HW = 12;
  localparam int VW = 11;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b0;
  localparam int D_HA = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VA = 6,   D_VF = 2,  D_VS = 2,  D_VB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, cfg_err, hsync, vsync, active, line_start, frame_start;
  logic [HW-1:0] cfg_h_active = '0, cfg_h_fp = '0, cfg_h_sync = '0, cfg_h_bp = '0;
  logic [VW-1:0] cfg_v_active = '0, cfg_v_fp = '0, cfg_v_sync = '0, cfg_v_bp = '0;
  logic [HW-1:0] x;
  logic [VW-1:0] y;

  vga_timing_gen #(
    .H_WIDTH(HW), .V_WIDTH(VW), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
    .DEF_H_ACTIVE(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB),
    .DEF_V_ACTIVE(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_err(cfg_err), .hsync(hsync), .vsync(vsync), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- behavioural model ----------------
  int m_h[4], m_v[4], s_h[4], s_v[4];
  int m_p = 0, m_phase = 0;
  bit m_on = 1'b0;
  bit e_hs, e_vs, e_act, e_ls, e_fs, e_err, e_rdy;
  int e_x, e_y;

  function automatic int seg_sum(input int a[4]);
    return a[0] + a[1] + a[2] + a[3];
  endfunction

  function automatic bit cfg_ok(input int h[4], input int v[4]);
    for (int i = 0; i < 4; i++) if (h[i] == 0 || v[i] == 0) return 1'b0;
    return (seg_sum(h) <= (1 << HW)) && (seg_sum(v) <= (1 << VW));
  endfunction

  always @(posedge clk) begin : model
    bit cap, fe, app;
    int ht, vt, hc, vc;
    if (!rst_n) begin
      m_on = 1'b1;
      m_h = '{D_HA, D_HF, D_HS, D_HB};
      m_v = '{D_VA, D_VF, D_VS, D_VB};
      m_p = 0; m_phase = 0;
      e_hs = ~HPOL; e_vs = ~VPOL; e_act = 1'b0; e_x = 0; e_y = 0;
      e_ls = 1'b0; e_fs = 1'b0; e_err = 1'b0; e_rdy = 1'b1;
    end else if (m_on) begin
      ht  = seg_sum(m_h);
      vt  = seg_sum(m_v);
      cap = cfg_valid && e_rdy;
      fe  = enable && (m_p == ht * vt - 1);
      app = 1'b0;
      e_err = 1'b0;
      if (m_phase == 1) begin
        if (!cfg_ok(s_h, s_v)) begin e_err = 1'b1; e_rdy = 1'b1; m_phase = 0; end
        else if (fe) begin app = 1'b1; e_rdy = 1'b1; m_phase = 0; end
        else m_phase = 2;
      end else if (m_phase == 2 && fe) begin
        app = 1'b1; e_rdy = 1'b1; m_phase = 0;
      end
      e_ls = 1'b0;
      e_fs = 1'b0;
      if (enable) begin
        hc    = m_p % ht;
        vc    = m_p / ht;
        e_x   = hc;
        e_y   = vc;
        e_act = (hc < m_h[0]) && (vc < m_v[0]);
        e_hs  = (hc >= m_h[0] + m_h[1] && hc < m_h[0] + m_h[1] + m_h[2]) ? HPOL : ~HPOL;
        e_vs  = (vc >= m_v[0] + m_v[1] && vc < m_v[0] + m_v[1] + m_v[2]) ? VPOL : ~VPOL;
        e_ls  = (hc == 0);
        e_fs  = (m_p == 0);
        m_p   = (m_p + 1) % (ht * vt);
      end
      if (app) begin
        m_h = s_h;
        m_v = s_v;
      end
      if (cap) begin
        s_h = '{int'(cfg_h_active), int'(cfg_h_fp), int'(cfg_h_sync), int'(cfg_h_bp)};
        s_v = '{int'(cfg_v_active), int'(cfg_v_fp), int'(cfg_v_sync), int'(cfg_v_bp)};
        e_rdy = 1'b0;
        m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [29:0] got_v, exp_v;
    if (m_on) begin
      got_v = {x, y, hsync, vsync, active, line_start, frame_start, cfg_err, cfg_ready};
      exp_v = {HW'(e_x), VW'(e_y), e_hs, e_vs, e_act, e_ls, e_fs, e_err, e_rdy};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL model t=%0t: got x=%0d y=%0d flags(hs,vs,act,ls,fs,err,rdy)=%b expected x=%0d y=%0d flags=%b",
                 $time, x, y, got_v[6:0], e_x, e_y, exp_v[6:0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input int h0, h1, h2, h3, v0, v1, v2, v3);
    int k;
    for (k = 0; k < 5000 && cfg_ready !== 1'b1; k++) step();
    if (cfg_ready !== 1'b1) timeout("offer_ready");
    cfg_h_active = HW'(h0); cfg_h_fp = HW'(h1); cfg_h_sync = HW'(h2); cfg_h_bp = HW'(h3);
    cfg_v_active = VW'(v0); cfg_v_fp = VW'(v1); cfg_v_sync = VW'(v2); cfg_v_bp = VW'(v3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Returns at a frame_start sample; n = clks since the previous frame_start.
  task automatic fs_period(output int n);
    int k;
    n = -1;
    for (k = 0; k < 30000 && frame_start !== 1'b1; k++) step();
    if (frame_start !== 1'b1) begin timeout("fs_first"); return; end
    for (int c = 1; c < 30000; c++) begin
      step();
      if (frame_start === 1'b1) begin n = c; return; end
    end
    timeout("fs_next");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_active"}, active, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_line_start"}, line_start, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hl, vl, ac, ls;
    int fs_t[$];

    // Reset and first tick with default timing (800 x 13 lines).
    rst_n = 1'b0; enable = 1'b1;
    step(); step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();
    check("first_x", x, 0);
    check("first_y", y, 0);
    check("first_active", active, 1);
    check("first_line_start", line_start, 1);
    check("first_frame_start", frame_start, 1);

    hl = 0; vl = 0; ac = 0; ls = 0;
    for (int i = 0; i < 10400; i++) begin
      if (hsync === 1'b0) hl++;
      if (vsync === 1'b0) vl++;
      if (active === 1'b1) ac++;
      if (line_start === 1'b1) ls++;
      step();
    end
    check("def_hsync_low_clks", hl, 96 * 13);
    check("def_vsync_low_clks", vl, 2 * 800);
    check("def_active_clks", ac, 640 * 6);
    check("def_line_starts", ls, 13);
    check("def_frame_period", frame_start, 1);

    // Mid-frame reprogram to 7 x 5.
    repeat (3000) step();
    offer(4, 1, 1, 1, 2, 1, 1, 1);
    check("ready_dropped", cfg_ready, 0);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 20000) begin step(); n++; end
    if (cfg_ready !== 1'b1) timeout("ready_rise");
    check("ready_before_fs", frame_start, 0);
    step();
    check("new_frame_fs", frame_start, 1);
    for (int i = 0; i < 35; i++) begin
      check("small_x", x, i % 7);
      check("small_y", y, i / 7);
      check("small_hsync", hsync, (i % 7 == 5) ? 0 : 1);
      step();
    end
    check("small_frame_period", frame_start, 1);

    // Rejected configurations.
    offer(4, 1, 0, 1, 2, 1, 1, 1);
    step();
    check("zero_field_err", cfg_err, 1);
    check("zero_field_ready", cfg_ready, 1);
    step();
    check("zero_field_err_clear", cfg_err, 0);
    offer(4000, 32, 32, 33, 2, 1, 1, 1);
    step();
    check("ht4097_err", cfg_err, 1);
    check("ht4097_ready", cfg_ready, 1);
    step();
    check("ht4097_err_clear", cfg_err, 0);
    fs_period(n);
    fs_period(n);
    check("timing_unchanged_period", n, 35);

    // Enable one clk in three.
    for (int i = 0; i < 400; i++) begin
      enable = (i % 3 == 0);
      step();
      if (frame_start === 1'b1) fs_t.push_back(i);
    end
    enable = 1'b1;
    if (fs_t.size() >= 2) check("slow_frame_period", fs_t[1] - fs_t[0], 105);
    else timeout("slow_frame_starts");

    // Config captured on the frame-end edge applies one frame later.
    n = 0;
    while (m_p != 34 && n < 200) begin step(); n++; end
    if (m_p != 34) timeout("frame_end_align");
    offer(3, 1, 1, 1, 2, 1, 1, 1);
    fs_period(n);
    check("fe_capture_old_period", n, 35);
    fs_period(n);
    check("fe_capture_new_period", n, 30);

    // Randomized enable and configuration traffic.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      cfg_h_active = HW'($urandom_range(0, 5)); cfg_h_fp = HW'($urandom_range(0, 5));
      cfg_h_sync   = HW'($urandom_range(0, 5)); cfg_h_bp = HW'($urandom_range(0, 5));
      cfg_v_active = VW'($urandom_range(0, 4)); cfg_v_fp = VW'($urandom_range(0, 4));
      cfg_v_sync   = VW'($urandom_range(0, 4)); cfg_v_bp = VW'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) cfg_h_active = HW'($urandom_range(4094, 4095));
      cfg_valid = ($urandom_range(0, 15) == 0);
      step();
    end
    cfg_valid = 1'b0;
    enable = 1'b1;

    // Reset mid-frame with a configuration pending.
    n = 0;
    while (cfg_ready !== 1'b1 && n < 2000) begin step(); n++; end
    fs_period(n);
    offer(4, 1, 1, 1, 2, 1, 1, 1);
    step();
    rst_n = 1'b0;
    step();
    check_reset_vals("midreset");
    rst_n = 1'b1;
    step();
    check("midreset_first_fs", frame_start, 1);
    fs_period(n);
    check("midreset_default_period", n, 800 * 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Two-dimensional VGA timing generator producing horizontal and vertical sync, active-video, pixel coordinates and line/frame strobes from a single pixel-rate enable. It is the generalised successor of the single-axis sync generator and adds several capabilities: programmable counter widths, sync polarity, reset, and runtime-reprogrammable timing that is applied glitch-free at frame boundaries. It sits between the pixel-clock enable source and the framebuffer/pixel pipeline.

## Interface
- H_WIDTH, 12, width of horizontal counter, x output and horizontal config fields
- V_WIDTH, 11, width of vertical counter, y output and vertical config fields
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync (0 = active-low)
- DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, horizontal timing loaded at reset
- DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, vertical timing loaded at reset

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  pixel tick; counters and outputs advance only when high
- cfg_valid  in  1  new timing offered
- cfg_ready  out  1  block can accept new timing
- cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  H_WIDTH each  horizontal segment lengths in pixels
- cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  V_WIDTH each  vertical segment lengths in lines
- cfg_err  out  1  one-clk pulse: offered timing rejected
- hsync, vsync  out  1  sync outputs at configured polarity
- active  out  1  pixel is in active area (both axes)
- x  out  H_WIDTH  horizontal position
- y  out  V_WIDTH  vertical position
- line_start, frame_start  out  1  one-clk strobes

## Operation
- Horizontal counter hcnt runs 0..HT-1, where HT = h_active+h_fp+h_sync+h_bp. Segments are ordered active [0, ha-1], front porch, sync, back porch.
- Vertical counter vcnt increments on an enable tick where hcnt==HT-1. It wraps to 0 after VT-1, and uses the same segment ordering in lines.
- hsync is asserted while hcnt is in the h sync segment. vsync is asserted while vcnt is in the v sync segment; vsync transitions coincide with the line start.
- active = hcnt<ha && vcnt<va. x = hcnt and y = vcnt, raw and valid in blanking too.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready; the fields are captured into a shadow set and cfg_ready drops.
  - A shadow set is rejected if any field is 0, or if HT > 2^H_WIDTH or VT > 2^V_WIDTH. Totals are computed with 2 guard bits.
  - On rejection: cfg_err pulses the clk after capture, the shadow is discarded, and cfg_ready returns high that same clk.
  - A valid shadow is pending until the frame-end tick (enable && hcnt==HT-1 && vcnt==VT-1). On that tick the shadow is copied to the working timing, and cfg_ready rises the following clk.
  - A transfer captured on the same clk as a frame-end tick is not applied at that boundary; it waits for the next one.
- Reset (rst_n low at a clk edge): working timing = DEF_* values, hcnt=vcnt=0, pending cleared. Outputs: hsync=~HSYNC_POL, vsync=~VSYNC_POL, active=0, x=0, y=0, line_start=0, frame_start=0, cfg_err=0, cfg_ready=1. A reset mid-frame or mid-handshake discards any pending config.

## Timing
- All outputs are registered. On an enable tick, outputs take values describing the (hcnt, vcnt) held before that tick's increment, giving 1-tick latency. Level outputs hold between ticks.
- line_start is high for exactly one clk after a tick at which hcnt==0. frame_start is high for exactly one clk after a tick at which hcnt==0 && vcnt==0.
- The first tick after reset produces x=0, y=0, active=1, line_start=1, frame_start=1.
- The new timing governs the first tick of the next frame (counters 0,0); there is no partial or torn frame.
- With enable held high, the period is HT clks per line and HT*VT clks per frame.

## Test plan
- Defaults, enable constant high: hsync low for 96 clks every 800; vsync low for 2 lines every 525; active count per frame = 307200; frame_start period 420000 clks.
- Program h=4/1/1/1, v=2/1/1/1 mid-frame: the old timing completes the frame; the next frame has period 35 clks; cfg_ready rises one clk after the frame-end tick; x sequence 0..6; hsync asserted at x=5; frame_start period 35.
- Offer a cfg_h_sync=0 config, and separately a config with HT=4097 at H_WIDTH=12: each gives one cfg_err pulse, cfg_ready high the next clk, and timing unchanged.
- enable toggling 1-of-3 clks with small timing: outputs change only after enable ticks; strobes last exactly 1 clk; the frame takes 3*35 clks.
- Config accepted on the frame-end clk: it applies one full frame later.
- Assert rst_n low mid-frame with a config pending: all outputs take their reset values, DEF_* timing is restored, and the first tick gives frame_start=1.
